// File: rtl/mix_engine_if.sv
// Seed/result handshake bundle for mix_engine.
// The engine sits on the slave modport and the seed producer on the master modport.
interface mix_engine_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 8,
  parameter int RW    = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [RW-1:0]          in_rounds;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   busy;
  logic [15:0]            op_count;

  modport master (
    output in_valid, in_data, in_rounds, out_ready,
    input  in_ready, out_valid, out_data, busy, op_count
  );

  modport slave (
    input  in_valid, in_data, in_rounds, out_ready,
    output in_ready, out_valid, out_data, busy, op_count
  );
endinterface

// File: rtl/mix_engine.sv
// Multi-lane iterative mixer: loads a seed, runs R rounds of four stages, presents the result.
//   state   | meaning
//   IDLE    | waiting for a seed, in_ready high
//   RUN     | one stage per clock, rcnt counts down rounds
//   DONE    | result held on out_data until out_ready
module mix_engine #(
  parameter int WIDTH = 32,
  parameter int LANES = 8,
  parameter int SHL   = 16,
  parameter int RW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  mix_engine_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_stage;
  logic [RW-1:0]    r_rcnt;
  logic [15:0]      r_op_count;
  logic [WIDTH-1:0] r_lane [LANES];

  logic [WIDTH-1:0] w_s0   [LANES];
  logic [WIDTH-1:0] w_s1   [LANES];
  logic [WIDTH-1:0] w_s2   [LANES];
  logic [WIDTH-1:0] w_s3   [LANES];
  logic [WIDTH-1:0] w_next [LANES];

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      localparam int NB = (g + 3) % LANES;
      assign w_s0[g] = r_lane[g] + WIDTH'(g);
      assign w_s2[g] = r_lane[g] ^ (r_lane[NB] << SHL);
      assign w_s3[g] = r_lane[g] * WIDTH'(2 * g + 3) + WIDTH'(g + 1);
      assign bus.out_data[g*WIDTH +: WIDTH] = r_lane[g];
    end
  endgenerate

  // Chain stage ripples through the freshly computed lower lanes in one cycle.
  always_comb begin
    w_s1[0] = r_lane[0] + r_lane[LANES-1];
    for (int i = 1; i < LANES; i++) begin
      w_s1[i] = r_lane[i] + w_s1[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      case (r_stage)
        2'd0:    w_next[i] = w_s0[i];
        2'd1:    w_next[i] = w_s1[i];
        2'd2:    w_next[i] = w_s2[i];
        default: w_next[i] = w_s3[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_stage    <= 2'd0;
      r_rcnt     <= '0;
      r_op_count <= 16'd0;
      for (int i = 0; i < LANES; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < LANES; i++) begin
              r_lane[i] <= bus.in_data[i*WIDTH +: WIDTH];
            end
            r_rcnt  <= bus.in_rounds;
            r_stage <= 2'd0;
            r_state <= (bus.in_rounds != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < LANES; i++) begin
            r_lane[i] <= w_next[i];
          end
          r_stage <= r_stage + 2'd1;
          if (r_stage == 2'd3) begin
            r_rcnt <= r_rcnt - RW'(1);
            if (r_rcnt == RW'(1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state    <= ST_IDLE;
            r_op_count <= r_op_count + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.op_count  = r_op_count;

endmodule

// File: doc/mix_engine.md
Name: mix_engine

Overview:
- Parametrised multi-lane iterative mixing engine: LANES registers of WIDTH bits, scrambled by a fixed four-stage round sequence.
- Each operation is a seed vector loaded via a valid/ready handshake, then a selectable number of rounds, then the result presented on a valid/ready output.
- Successor to the fixed 8x32 free-running mixer: width, lane count, round count and shift amounts are configurable; start/done handshake, round control and reset are added.
- Used as a simulator-throughput workload and as a checkable arithmetic datapath.

Parameters:
- WIDTH, 32, bits per lane (>=8)
- LANES, 8, number of lanes (>=2)
- SHL, 16, left-shift amount in stage S2 (< WIDTH)
- RW, 8, width of the round-count input

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  seed vector valid
- in_ready  out  1  engine accepts a seed
- in_data  in  LANES*WIDTH  seed vector; lane i = bits [i*WIDTH +: WIDTH]
- in_rounds  in  RW  rounds to run; sampled with in_data
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  LANES*WIDTH  result vector, same lane packing as in_data
- busy  out  1  high in RUN or DONE
- op_count  out  16  completed (consumed) operations; wraps mod 2^16

Behaviour:
- Design has one clock and one reset. Reset is synchronous and active-high; rst is sampled on the rising edge of clk.
- Reset state:
  - state = IDLE; all lane registers = 0; round and stage counters = 0.
  - op_count = 0, in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
- Reset mid-operation abandons the operation; no output is produced.
- Idle and load:
  - In IDLE, in_ready = 1.
  - On an edge with in_valid & in_ready: lanes <- in_data, rcnt <- in_rounds, stage <- 0.
  - Next state is RUN if in_rounds != 0, otherwise DONE.
- RUN:
  - Each edge applies one stage to all lanes, then advances stage 0->1->2->3->0.
  - After stage 3, rcnt is decremented. When rcnt reaches 0 after stage 3, the next state is DONE.
- Stage definitions. i = lane index, arithmetic mod 2^WIDTH, lane indices mod LANES, o = value before the edge, n = value after:
  - S0 (add constant): n[i] = o[i] + i
  - S1 (chain): n[0] = o[0] + o[LANES-1]; n[i] = o[i] + n[i-1] for i >= 1. Combinational ripple within one cycle.
  - S2 (xor-shift): n[i] = o[i] ^ ((o[i+3] << SHL) truncated to WIDTH). Uses old values only, applied in parallel.
  - S3 (multiply): n[i] = o[i]*(2i+3) + (i+1), truncated to WIDTH.
- DONE:
  - out_valid = 1, out_data = lanes (held stable while waiting), in_ready = 0.
  - On out_valid & out_ready: state -> IDLE and op_count increments.
- Latency:
  - Accept edge T gives out_valid high from the cycle after edge T+4R, where R = in_rounds.
  - R = 0 gives out_valid in the cycle after accept, with out_data = seed.
- in_ready is low throughout RUN and DONE. A seed presented in the same cycle as the output handshake is not accepted until IDLE is reached (one bubble cycle).
- in_data and in_rounds changing during RUN have no effect.
- busy = (state != IDLE).
- Maximum R = 2^RW - 1, which takes 4*(2^RW - 1) RUN cycles.

Test Plan:
- Config for directed checks: WIDTH=8, LANES=2, SHL=4.
  - Seed lane1/lane0 = 0x00/0x00, rounds=1, out_ready=1 -> out_valid exactly 4 cycles after the accept edge; out_data = 0x5C64; op_count 0->1.
  - Seed 0xFF/0xFF, rounds=1 -> out_data = 0x4D2E. Checks wrap of the add and truncation of the shift.
  - Seed 0xAB/0xCD, rounds=0 -> out_valid the cycle after accept; out_data = 0xABCD; in_ready low while out_valid is high.
- Backpressure: rounds=1, out_ready=0 for 10 cycles -> out_valid and out_data held stable, op_count unchanged. Then assert out_ready for one cycle -> IDLE next cycle, in_ready=1, op_count increments once.
- Reset mid-run: rounds=3, assert rst at RUN cycle 5 -> next cycle state IDLE, out_valid=0, busy=0, out_data=0, op_count=0. A following 0x00/0x00 rounds=1 operation still yields 0x5C64.
- Default config (32x8, SHL=16):
  - Random seeds and rounds in 0..5, back-to-back with random out_ready.
  - Results must match a bit-accurate reference model.
  - Latency must equal 4R cycles.
  - op_count must equal the number of output handshakes.
